// File: rtl/mem_mover_pkg.sv
// rtl/mem_mover_pkg.sv - state and mode encodings for the memory block mover
package mem_mover_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } mover_state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_block_mover.sv
// rtl/mem_block_mover.sv - bus initiator performing COPY/FILL block operations on a synchronous memory
module mem_block_mover
    import mem_mover_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  MODE,
    input  logic [ADDR_WIDTH-1:0] SRC_ADDR,
    input  logic [ADDR_WIDTH-1:0] DST_ADDR,
    input  logic [ADDR_WIDTH-1:0] LENGTH,
    input  logic [DATA_WIDTH-1:0] FILL_VAL,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [ADDR_WIDTH-1:0] ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA
);

    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

    mover_state_t          state;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [DATA_WIDTH-1:0] fill_q;
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wr_copy;
    logic [ADDR_WIDTH-1:0] idx_next;

    assign idx_next = idx + ONE_A;

    // COPY writes forward the registered memory output, so no START/state -> data loop exists
    assign MEM_WDATA = wr_copy ? MEM_RDATA : wdata_q;

    // Outputs are registered together with the state they belong to.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_COPY;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            fill_q   <= '0;
            idx      <= '0;
            wdata_q  <= '0;
            wr_copy  <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            ADDR     <= '0;
        end else begin
            wdata_q  <= '0;
            wr_copy  <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            ADDR     <= '0;
            case (state)
                ST_IDLE, ST_FIN: begin
                    if (START) begin
                        mode_q <= MODE;
                        src_q  <= SRC_ADDR;
                        dst_q  <= DST_ADDR;
                        len_q  <= LENGTH;
                        fill_q <= FILL_VAL;
                        idx    <= '0;
                        if (LENGTH == '0) begin
                            state <= ST_FIN;
                            DONE  <= 1'b1;
                        end else if (MODE == MODE_COPY) begin
                            state   <= ST_RD;
                            BUSY    <= 1'b1;
                            MemRead <= 1'b1;
                            ADDR    <= SRC_ADDR;
                        end else begin
                            state    <= ST_WR;
                            BUSY     <= 1'b1;
                            MemWrite <= 1'b1;
                            ADDR     <= DST_ADDR;
                            wdata_q  <= FILL_VAL;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    state    <= ST_WR;
                    BUSY     <= 1'b1;
                    MemWrite <= 1'b1;
                    ADDR     <= dst_q + idx;
                    wr_copy  <= 1'b1;
                end
                ST_WR: begin
                    if (idx == len_q - ONE_A) begin
                        state <= ST_FIN;
                        DONE  <= 1'b1;
                    end else if (mode_q == MODE_COPY) begin
                        state   <= ST_RD;
                        idx     <= idx_next;
                        BUSY    <= 1'b1;
                        MemRead <= 1'b1;
                        ADDR    <= src_q + idx_next;
                    end else begin
                        state    <= ST_WR;
                        idx      <= idx_next;
                        BUSY     <= 1'b1;
                        MemWrite <= 1'b1;
                        ADDR     <= dst_q + idx_next;
                        wdata_q  <= fill_q;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_block_mover.sv
// tb/tb_mem_block_mover.sv - self-checking bench for mem_block_mover wired to a 256x8 synchronous memory
module tb_mem_block_mover;
    import mem_mover_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET, START, MODE;
    logic [7:0] SRC_ADDR, DST_ADDR, LENGTH, FILL_VAL;
    logic       BUSY, DONE, MemRead, MemWrite;
    logic [7:0] ADDR, MEM_WDATA, MEM_RDATA;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic       tb_we;
    logic [7:0] tb_addr, tb_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       mode;
        logic [7:0] src;
        logic [7:0] dst;
        logic [7:0] len;
        logic [7:0] fill;
    } op_t;

    op_t plan [6];

    always #5 CLK = ~CLK;

    mem_block_mover #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .MODE(MODE),
        .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .LENGTH(LENGTH), .FILL_VAL(FILL_VAL),
        .BUSY(BUSY), .DONE(DONE), .MemRead(MemRead), .MemWrite(MemWrite),
        .ADDR(ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
    );

    // 256x8 memory with registered read data (one-cycle latency)
    always @(posedge CLK) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (MemWrite) mem[ADDR] <= MEM_WDATA;
        if (MemRead) MEM_RDATA <= mem[ADDR];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic poke_mem(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(posedge CLK);
        #1 tb_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic check_mem(input string name);
        int diffs = 0;
        for (int a = 0; a < 256; a++)
            if (mem[a] !== ref_mem[a]) diffs++;
        chk(name, diffs, 0);
    endtask

    // Applies one operation and checks every cycle of its bus trace against the
    // forward byte-by-byte semantics; returns at the negedge of the DONE cycle.
    task automatic run_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input logic [7:0] f,
                          input int poke, input int abort);
        int         total;
        logic [7:0] j, e_addr, e_data;
        logic       e_rd, e_wr, e_busy, e_done;
        MODE = m; SRC_ADDR = s; DST_ADDR = d; LENGTH = l; FILL_VAL = f;
        START = 1'b1;
        if (l == 0) total = 1;
        else if (m == MODE_COPY) total = 2 * int'(l) + 1;
        else total = int'(l) + 1;
        @(posedge CLK);
        #1 START = 1'b0;
        for (int c = 1; c <= total; c++) begin
            @(negedge CLK);
            e_rd = 0; e_wr = 0; e_busy = 0; e_done = 0; e_addr = 0; e_data = 0;
            if (c < total) begin
                e_busy = 1;
                if (m == MODE_COPY) begin
                    j = 8'((c - 1) / 2);
                    if (c % 2 == 1) begin
                        e_rd = 1; e_addr = s + j;
                    end else begin
                        e_wr = 1; e_addr = d + j; e_data = ref_mem[8'(s + j)];
                    end
                end else begin
                    j = 8'(c - 1);
                    e_wr = 1; e_addr = d + j; e_data = f;
                end
            end else begin
                e_done = 1;
            end
            chk($sformatf("trace m=%0d s=%02h d=%02h l=%0d cyc=%0d", m, s, d, l, c),
                {12'd0, MemRead, MemWrite, BUSY, DONE, ADDR, MEM_WDATA},
                {12'd0, e_rd, e_wr, e_busy, e_done, e_addr, e_data});
            if (e_wr) ref_mem[e_addr] = e_data;
            if (poke > 0 && c == poke) begin
                START = 1'b1; MODE = ~m;
                SRC_ADDR = 8'($urandom); DST_ADDR = 8'($urandom);
                LENGTH = 8'($urandom); FILL_VAL = 8'($urandom);
            end
            if (poke > 0 && c == poke + 1) START = 1'b0;
            if (c == abort) begin
                RESET = 1'b1;
                @(negedge CLK);
                RESET = 1'b0;
                chk("reset_mid_op_outputs",
                    {12'd0, MemRead, MemWrite, BUSY, DONE, ADDR, MEM_WDATA}, 32'd0);
                break;
            end
        end
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; MODE = 1'b0; SRC_ADDR = 0; DST_ADDR = 0;
        LENGTH = 0; FILL_VAL = 0; tb_we = 1'b0; tb_addr = 0; tb_data = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_outputs", {12'd0, MemRead, MemWrite, BUSY, DONE, ADDR, MEM_WDATA}, 32'd0);
        for (int a = 0; a < 256; a++) poke_mem(8'(a), 8'($urandom));
        RESET = 1'b0;

        poke_mem(8'h10, 8'hA1); poke_mem(8'h11, 8'hB2);
        poke_mem(8'h12, 8'hC3); poke_mem(8'h13, 8'hD4);
        poke_mem(8'h30, 8'h01); poke_mem(8'h31, 8'h02);
        poke_mem(8'h32, 8'h03); poke_mem(8'h33, 8'h04);

        plan[0] = '{MODE_COPY, 8'h10, 8'h80, 8'd4, 8'h00};
        plan[1] = '{MODE_FILL, 8'h00, 8'h20, 8'd5, 8'h5A};
        plan[2] = '{MODE_COPY, 8'hFE, 8'h40, 8'd3, 8'h00};
        plan[3] = '{MODE_FILL, 8'h00, 8'hFF, 8'd2, 8'hA5};
        plan[4] = '{MODE_COPY, 8'h12, 8'h90, 8'd0, 8'h00};
        plan[5] = '{MODE_COPY, 8'h30, 8'h31, 8'd3, 8'h00};
        for (int t = 0; t < 6; t++) begin
            run_op(plan[t].mode, plan[t].src, plan[t].dst, plan[t].len, plan[t].fill, 0, 0);
            check_mem($sformatf("mem_image plan%0d", t));
            @(negedge CLK);
        end
        chk("copy_dst_0x80", {mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]}, 32'hA1B2C3D4);
        chk("fill_dst_0x24", {24'd0, mem[8'h24]}, 32'h5A);
        chk("fill_wrap_0xFF_0x00", {16'd0, mem[8'hFF], mem[8'h00]}, 32'hA5A5);
        chk("overlap_0x31_0x33", {8'd0, mem[8'h31], mem[8'h32], mem[8'h33]}, 32'h010101);

        poke_mem(8'h60, 8'h11); poke_mem(8'h61, 8'h22);
        poke_mem(8'h62, 8'h33); poke_mem(8'h63, 8'h44);
        run_op(MODE_COPY, 8'h60, 8'hA0, 8'd4, 8'h00, 3, 0);
        check_mem("mem_image start_while_busy");
        chk("start_while_busy_dst", {mem[8'hA0], mem[8'hA1], mem[8'hA2], mem[8'hA3]}, 32'h11223344);
        @(negedge CLK);

        run_op(MODE_FILL, 8'h00, 8'hB0, 8'd2, 8'h77, 0, 0);
        run_op(MODE_COPY, 8'hB0, 8'hC0, 8'd2, 8'h00, 0, 0);
        run_op(MODE_COPY, 8'h00, 8'h00, 8'd0, 8'h00, 0, 0);
        check_mem("mem_image back_to_back");
        chk("back_to_back_dst", {16'd0, mem[8'hC0], mem[8'hC1]}, 32'h7777);
        @(negedge CLK);

        run_op(MODE_COPY, 8'h10, 8'hD0, 8'd4, 8'h00, 0, 4);
        check_mem("mem_image reset_mid_copy");
        chk("reset_mid_copy_written", {16'd0, mem[8'hD0], mem[8'hD1]}, 32'hA1B2);
        @(negedge CLK);

        for (int r = 0; r < 30; r++) begin
            run_op(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 24)),
                   8'($urandom), 0, 0);
            if ($urandom_range(0, 1) == 1) @(negedge CLK);
        end
        @(negedge CLK);
        check_mem("mem_image random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
